// File: rtl/lsu_dm_port.sv
// rtl/lsu_dm_port.sv - MEM-stage load/store initiator for a word-addressed data memory
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module lsu_dm_port #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  memwrite,
  output logic                  memread,
  input  logic [31:0]           mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RSP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  we_q, we_d;
  logic [31:0]           din_q, din_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [1:0]            req_size_n;
  logic [ADDR_WIDTH-1:0] req_addr_a;
  logic                  misaligned;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: format_load = {{24{sgn & b[7]}}, b};
      SZ_HALF: format_load = {{16{sgn & h[15]}}, h};
      default: format_load = word;
    endcase
  endfunction

  // Only the addressed lane(s) take store data; the rest keep the word just read.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          default: m[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) m[31:16] = wd[15:0];
        else         m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  always_comb begin
    req_size_n = (req_size == 2'b11) ? SZ_WORD : req_size;
    req_addr_a = req_addr[ADDR_WIDTH-1:0];
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                 ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size_n == SZ_WORD)      req_addr_a[1:0] = 2'b00;
    else if (req_size_n == SZ_HALF) req_addr_a[0]   = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    we_d     = we_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr_a;
          size_d   = req_size_n;
          signed_d = req_signed;
          we_d     = req_we;
          rdata_d  = '0;
          err_d    = misaligned;
          if (req_we) din_d = req_wdata;
          // Word stores need no read; sub-word stores read first to merge.
          if (misaligned)                            state_d = S_RSP;
          else if (req_we && req_size_n == SZ_WORD)  state_d = S_WR;
          else                                       state_d = S_RD;
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (we_q) begin
          din_d   = merge_store(mem_dout, din_q, size_q, addr_q[1:0]);
          state_d = S_WR;
        end else begin
          rdata_d = format_load(mem_dout, size_q, addr_q[1:0], signed_q);
          state_d = S_RSP;
        end
      end
      S_WR: state_d = S_RSP;
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      din_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      we_q     <= we_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign req_ready = (state_q == S_IDLE);
  assign memread   = (state_q == S_RD);
  assign memwrite  = (state_q == S_WR);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = addr_q[ADDR_WIDTH-1:2];
  assign mem_din   = din_q;

endmodule
